branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter BP_GHR_BITS, default 8: global history length; the BHT has 2^BP_GHR_BITS entries.
REQ-002 SHALL have parameter BP_BTB_IDX_BITS, default 6: the BTB has 2^BP_BTB_IDX_BITS entries.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 fetch_valid  input  1  fetch stage presents a PC this cycle.
REQ-006 fetch_pc  input  32  fetch PC.
REQ-007 pred_taken  output  1  predicted direction for fetch_pc.
REQ-008 pred_target  output  32  predicted next PC.
REQ-009 pred_ghr  output  BP_GHR_BITS  GHR snapshot used for this lookup; carried down the pipe.
REQ-010 upd_valid  input  1  a conditional branch resolved at the compare stage this cycle.
REQ-011 upd_pc  input  32  PC of the resolved branch.
REQ-012 upd_taken  input  1  actual outcome (comparator br_en).
REQ-013 upd_target  input  32  actual taken target.
REQ-014 upd_ghr  input  BP_GHR_BITS  pred_ghr originally returned for this branch.
REQ-015 upd_mispredict  input  1  predicted direction or target was wrong.

Function
REQ-016 BHT index SHALL be fetch_pc[BP_GHR_BITS+1:2] XOR ghr; BTB index SHALL be fetch_pc[BP_BTB_IDX_BITS+1:2]; BTB tag SHALL be fetch_pc[31:BP_BTB_IDX_BITS+2].
REQ-017 Lookup SHALL be combinational from registered state (zero-cycle latency).
REQ-018 BTB hit SHALL mean the entry is valid and its tag equals the fetch tag.
REQ-019 pred_taken SHALL be 1 only when the BTB hits and BHT counter bit[1]=1.
REQ-020 pred_target SHALL be the BTB target when pred_taken=1; otherwise fetch_pc+4 (mod 2^32).
REQ-021 pred_ghr SHALL equal the current ghr register.
REQ-022 On fetch_valid with a BTB hit, ghr SHALL shift left with pred_taken inserted at bit 0 (speculative); no shift otherwise.
REQ-023 On upd_valid and upd_mispredict, ghr SHALL load {upd_ghr[BP_GHR_BITS-2:0], upd_taken}; this overrides a same-cycle speculative shift.
REQ-024 On upd_valid, the BHT entry at upd_pc[BP_GHR_BITS+1:2] XOR upd_ghr SHALL increment on taken (saturate at 3) and decrement on not-taken (saturate at 0).
REQ-025 On upd_valid and upd_taken, the BTB entry SHALL be written with valid=1, the tag from upd_pc, and upd_target; not-taken updates SHALL leave the BTB unchanged.
REQ-026 When a lookup and an update touch the same entry in one cycle, the lookup SHALL see the pre-update value (no bypass).
REQ-027 upd_valid=0 SHALL leave the BHT, BTB and ghr unaffected by the update inputs.

Reset
REQ-028 While rst=0: every BHT counter SHALL be 2'b01 (weakly not-taken), every BTB valid bit 0, and ghr 0, asynchronously.
REQ-029 Consequently, during and after reset pred_taken=0, pred_target=fetch_pc+4 and pred_ghr=0.
REQ-030 Asserting reset mid-training SHALL discard all learned state immediately, without waiting for a clock edge.

Structure
REQ-031 Package rv32i_types SHALL hold bp_ctr_t (SNT=00, WNT=01, WT=10, ST=11) and the default values of BP_GHR_BITS and BP_BTB_IDX_BITS.
REQ-032 The BTB (valid/tag/target arrays, hit compare, write port) SHALL be the sub-module bp_btb; the BHT and ghr stay in branch_predictor.

Verification
REQ-033 Reset: rst=0, fetch_pc=0x40 -> pred_taken=0, pred_target=0x44, pred_ghr=0x00.
REQ-034 Train: update pc=0x100, taken=1, target=0x80, ghr=0, mispredict=0; then fetch 0x100 with valid=1 -> pred_taken=1, pred_target=0x80; next cycle pred_ghr=0x01.
REQ-035 Saturation: 4 taken updates at pc=0x100, ghr=0 -> counter ST; 1 not-taken update -> still predicts taken; 2nd not-taken update -> pred_taken=0, pred_target=0x104.
REQ-036 Recovery: ghr=0xA5; same cycle, BTB-hit fetch plus mispredict update with upd_ghr=0x3C, taken=0 -> ghr=0x78 next cycle.
REQ-037 Alias: train pc=0x100 taken; fetch 0x200 (same BTB index, different tag) -> pred_taken=0, pred_target=0x204.
REQ-038 Async reset: after REQ-034 training, pulse rst low between edges -> pred_taken falls to 0 before the next clk edge.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types and default sizing for the branch predictor.
// The 2-bit direction counter and its saturating step live here so every user agrees on them.
package rv32i_types;

   localparam int BP_GHR_BITS_DEFAULT     = 8;
   localparam int BP_BTB_IDX_BITS_DEFAULT = 6;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } bp_ctr_t;

   function automatic bp_ctr_t bp_ctr_next(input bp_ctr_t ctr, input logic taken);
      bp_ctr_t nxt;
      nxt = ctr;
      if (taken) begin
         if (ctr != ST) nxt = bp_ctr_t'(ctr + 2'd1);
      end else begin
         if (ctr != SNT) nxt = bp_ctr_t'(ctr - 2'd1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: valid/tag/target arrays with a combinational hit compare.
// Only the valid bits are reset; tag and target contents are meaningless while valid is low.
module bp_btb
   import rv32i_types::*;
#(
   parameter int IDX_BITS = BP_BTB_IDX_BITS_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IDX_BITS-1:0]  rd_idx,
   input  logic [29-IDX_BITS:0] rd_tag,
   output logic                 hit,
   output logic [31:0]          rd_target,
   input  logic                 wr_en,
   input  logic [IDX_BITS-1:0]  wr_idx,
   input  logic [29-IDX_BITS:0] wr_tag,
   input  logic [31:0]          wr_target
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [ENTRIES-1:0]   valid_q;
   logic [29-IDX_BITS:0] tag_q    [ENTRIES];
   logic [31:0]          target_q [ENTRIES];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
      end else if (wr_en) begin
         valid_q[wr_idx] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
      end
   end

   // Reads see the pre-write contents, so a same-cycle write never bypasses to the lookup.
   assign hit       = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
   assign rd_target = target_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Gshare direction predictor (global history XOR PC into a 2-bit counter table) plus BTB.
// The history register is updated speculatively at fetch and repaired on a resolved mispredict.
module branch_predictor
   import rv32i_types::*;
#(
   parameter int BP_GHR_BITS     = BP_GHR_BITS_DEFAULT,
   parameter int BP_BTB_IDX_BITS = BP_BTB_IDX_BITS_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   fetch_valid,
   input  logic [31:0]            fetch_pc,
   output logic                   pred_taken,
   output logic [31:0]            pred_target,
   output logic [BP_GHR_BITS-1:0] pred_ghr,
   input  logic                   upd_valid,
   input  logic [31:0]            upd_pc,
   input  logic                   upd_taken,
   input  logic [31:0]            upd_target,
   input  logic [BP_GHR_BITS-1:0] upd_ghr,
   input  logic                   upd_mispredict
);

   localparam int BHT_ENTRIES = 1 << BP_GHR_BITS;

   bp_ctr_t                bht_q [BHT_ENTRIES];
   logic [BP_GHR_BITS-1:0] ghr_q;
   logic [BP_GHR_BITS-1:0] ghr_d;
   logic [BP_GHR_BITS-1:0] fetch_bht_idx;
   logic [BP_GHR_BITS-1:0] upd_bht_idx;
   logic                   btb_hit;
   logic [31:0]            btb_target;
   logic                   unused_pc_low;

   assign unused_pc_low = ^{fetch_pc[1:0], upd_pc[1:0]};

   assign fetch_bht_idx = fetch_pc[BP_GHR_BITS+1:2] ^ ghr_q;
   assign upd_bht_idx   = upd_pc[BP_GHR_BITS+1:2] ^ upd_ghr;

   bp_btb #(
      .IDX_BITS (BP_BTB_IDX_BITS)
   ) u_btb (
      .clk       (clk),
      .rst       (rst),
      .rd_idx    (fetch_pc[BP_BTB_IDX_BITS+1:2]),
      .rd_tag    (fetch_pc[31:BP_BTB_IDX_BITS+2]),
      .hit       (btb_hit),
      .rd_target (btb_target),
      .wr_en     (upd_valid && upd_taken),
      .wr_idx    (upd_pc[BP_BTB_IDX_BITS+1:2]),
      .wr_tag    (upd_pc[31:BP_BTB_IDX_BITS+2]),
      .wr_target (upd_target)
   );

   // Only branches already known to the BTB are predicted taken.
   assign pred_taken  = btb_hit && bht_q[fetch_bht_idx][1];
   assign pred_target = pred_taken ? btb_target : (fetch_pc + 32'd4);
   assign pred_ghr    = ghr_q;

   always_comb begin
      ghr_d = ghr_q;
      if (fetch_valid && btb_hit) begin
         ghr_d = {ghr_q[BP_GHR_BITS-2:0], pred_taken};
      end
      // Mispredict repair rebuilds history from the branch's own snapshot and wins over speculation.
      if (upd_valid && upd_mispredict) begin
         ghr_d = {upd_ghr[BP_GHR_BITS-2:0], upd_taken};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ghr_q <= '0;
      end else begin
         ghr_q <= ghr_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_q[i] <= WNT;
         end
      end else if (upd_valid) begin
         bht_q[upd_bht_idx] <= bp_ctr_next(bht_q[upd_bht_idx], upd_taken);
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios against fixed expected values,
// then randomized traffic against a table-level behavioural model of the predictor.
module tb_branch_predictor;

   localparam int GB = 8;
   localparam int IB = 6;

   logic          clk;
   logic          rst;
   logic          fetch_valid;
   logic [31:0]   fetch_pc;
   logic          pred_taken;
   logic [31:0]   pred_target;
   logic [GB-1:0] pred_ghr;
   logic          upd_valid;
   logic [31:0]   upd_pc;
   logic          upd_taken;
   logic [31:0]   upd_target;
   logic [GB-1:0] upd_ghr;
   logic          upd_mispredict;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: counters as plain integers 0..3, BTB as parallel arrays.
   int            m_bht [1 << GB];
   bit            m_val [1 << IB];
   logic [31:0]   m_tag [1 << IB];
   logic [31:0]   m_tgt [1 << IB];
   logic [GB-1:0] m_ghr;

   branch_predictor dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_valid    (fetch_valid),
      .fetch_pc       (fetch_pc),
      .pred_taken     (pred_taken),
      .pred_target    (pred_target),
      .pred_ghr       (pred_ghr),
      .upd_valid      (upd_valid),
      .upd_pc         (upd_pc),
      .upd_taken      (upd_taken),
      .upd_target     (upd_target),
      .upd_ghr        (upd_ghr),
      .upd_mispredict (upd_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int i = 0; i < (1 << GB); i++) m_bht[i] = 1;
      for (int i = 0; i < (1 << IB); i++) m_val[i] = 1'b0;
      m_ghr = '0;
   endfunction

   function automatic bit model_hit(input logic [31:0] pc);
      int slot;
      slot = int'((pc / 4) % (1 << IB));
      return m_val[slot] && (m_tag[slot] == (pc / (4 * (1 << IB))));
   endfunction

   function automatic void model_predict(input logic [31:0] pc, output bit taken,
                                         output logic [31:0] target);
      int slot;
      int cidx;
      slot   = int'((pc / 4) % (1 << IB));
      cidx   = int'((pc / 4) % (1 << GB)) ^ int'(m_ghr);
      taken  = model_hit(pc) && (m_bht[cidx] >= 2);
      target = taken ? m_tgt[slot] : pc + 32'd4;
   endfunction

   function automatic void model_step();
      bit            ptaken;
      logic [31:0]   ptgt;
      logic [GB-1:0] nghr;
      int            cidx;
      int            slot;
      if (!rst) begin
         model_reset();
         return;
      end
      model_predict(fetch_pc, ptaken, ptgt);
      nghr = m_ghr;
      if (fetch_valid && model_hit(fetch_pc)) nghr = GB'((int'(m_ghr) * 2 + int'(ptaken)) % (1 << GB));
      if (upd_valid && upd_mispredict) nghr = GB'((int'(upd_ghr) * 2 + int'(upd_taken)) % (1 << GB));
      if (upd_valid) begin
         cidx = int'((upd_pc / 4) % (1 << GB)) ^ int'(upd_ghr);
         if (upd_taken) m_bht[cidx] = (m_bht[cidx] == 3) ? 3 : m_bht[cidx] + 1;
         else           m_bht[cidx] = (m_bht[cidx] == 0) ? 0 : m_bht[cidx] - 1;
         if (upd_taken) begin
            slot        = int'((upd_pc / 4) % (1 << IB));
            m_val[slot] = 1'b1;
            m_tag[slot] = upd_pc / (4 * (1 << IB));
            m_tgt[slot] = upd_target;
         end
      end
      m_ghr = nghr;
   endfunction

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_valid    = 1'b0;
      upd_valid      = 1'b0;
      upd_taken      = 1'b0;
      upd_mispredict = 1'b0;
      upd_pc         = '0;
      upd_target     = '0;
      upd_ghr        = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      model_reset();
      tick();
      rst = 1'b1;
   endtask

   task automatic send_update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                              input logic [GB-1:0] ghr, input logic misp);
      fetch_valid    = 1'b0;
      upd_valid      = 1'b1;
      upd_pc         = pc;
      upd_taken      = taken;
      upd_target     = tgt;
      upd_ghr        = ghr;
      upd_mispredict = misp;
      tick();
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst         = 1'b0;
      fetch_valid = 1'b1;
      fetch_pc    = 32'h40;
      model_reset();
      #1;
      n_checks++;
      if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %0b want 0", pred_taken); end
      n_checks++;
      if (pred_target !== 32'h44) begin n_fail++; $display("FAIL reset_target: got %h want 00000044", pred_target); end
      n_checks++;
      if (pred_ghr !== 8'h00) begin n_fail++; $display("FAIL reset_ghr: got %h want 00", pred_ghr); end
      tick();
      n_checks++;
      if (pred_ghr !== 8'h00 || pred_taken !== 1'b0) begin
         n_fail++; $display("FAIL reset_hold: ghr %h taken %0b want 00 0", pred_ghr, pred_taken);
      end
      $display("reset: pc=40 taken=%0b target=%h ghr=%h", pred_taken, pred_target, pred_ghr);
      rst = 1'b1;
   endtask

   task automatic test_train();
      do_reset();
      send_update(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
      fetch_valid = 1'b1;
      fetch_pc    = 32'h100;
      #1;
      n_checks++;
      if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL train_taken: got %0b want 1", pred_taken); end
      n_checks++;
      if (pred_target !== 32'h80) begin n_fail++; $display("FAIL train_target: got %h want 00000080", pred_target); end
      n_checks++;
      if (pred_ghr !== 8'h00) begin n_fail++; $display("FAIL train_ghr_before: got %h want 00", pred_ghr); end
      tick();
      fetch_valid = 1'b0;
      #1;
      n_checks++;
      if (pred_ghr !== 8'h01) begin n_fail++; $display("FAIL train_ghr_shift: got %h want 01", pred_ghr); end
      $display("train: pc=100 ghr after taken fetch=%h", pred_ghr);
   endtask

   task automatic test_saturation();
      do_reset();
      fetch_pc = 32'h100;
      for (int i = 0; i < 4; i++) send_update(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
      #1;
      n_checks++;
      if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL sat_strong: got %0b want 1", pred_taken); end
      send_update(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
      #1;
      n_checks++;
      if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin
         n_fail++; $display("FAIL sat_one_nt: taken %0b target %h want 1 00000080", pred_taken, pred_target);
      end
      send_update(32'h100, 1'b0, 32'h0, 8'h00, 1'b0);
      #1;
      n_checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         n_fail++; $display("FAIL sat_two_nt: taken %0b target %h want 0 00000104", pred_taken, pred_target);
      end
      $display("saturation: after 4T+2NT taken=%0b target=%h", pred_taken, pred_target);
   endtask

   task automatic test_recovery();
      do_reset();
      send_update(32'h300, 1'b1, 32'h500, 8'h52, 1'b1);
      #1;
      n_checks++;
      if (pred_ghr !== 8'hA5) begin n_fail++; $display("FAIL recov_setup_ghr: got %h want a5", pred_ghr); end
      fetch_valid    = 1'b1;
      fetch_pc       = 32'h300;
      upd_valid      = 1'b1;
      upd_pc         = 32'h400;
      upd_taken      = 1'b0;
      upd_target     = 32'h0;
      upd_ghr        = 8'h3C;
      upd_mispredict = 1'b1;
      tick();
      idle_inputs();
      n_checks++;
      if (pred_ghr !== 8'h78) begin n_fail++; $display("FAIL recov_ghr: got %h want 78", pred_ghr); end
      fetch_valid = 1'b1;
      fetch_pc    = 32'h300;
      tick();
      n_checks++;
      if (pred_ghr !== 8'hF0) begin n_fail++; $display("FAIL spec_shift_hit: got %h want f0", pred_ghr); end
      fetch_pc = 32'h304;
      tick();
      fetch_valid = 1'b0;
      n_checks++;
      if (pred_ghr !== 8'hF0) begin n_fail++; $display("FAIL no_shift_miss: got %h want f0", pred_ghr); end
      $display("recovery: ghr after repair/hit/miss = 78/f0/%h", pred_ghr);
   endtask

   task automatic test_alias();
      do_reset();
      send_update(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
      fetch_pc = 32'h200;
      #1;
      n_checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin
         n_fail++; $display("FAIL alias_miss: taken %0b target %h want 0 00000204", pred_taken, pred_target);
      end
      fetch_pc = 32'h100;
      #1;
      n_checks++;
      if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_owner: got %0b want 1", pred_taken); end
      $display("alias: pc=200 target=%h", (pred_taken ? 32'h0 : 32'h204));
   endtask

   task automatic test_async_reset();
      do_reset();
      send_update(32'h100, 1'b1, 32'h80, 8'h00, 1'b0);
      fetch_pc = 32'h100;
      #1;
      n_checks++;
      if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL async_pre: got %0b want 1", pred_taken); end
      #2;
      rst = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (pred_taken !== 1'b0 || pred_target !== 32'h104) begin
         n_fail++; $display("FAIL async_drop: taken %0b target %h want 0 00000104", pred_taken, pred_target);
      end
      tick();
      rst = 1'b1;
      #1;
      n_checks++;
      if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL async_forgot: got %0b want 0", pred_taken); end
      $display("async_reset: taken after mid-cycle reset=%0b", pred_taken);
   endtask

   task automatic test_random();
      bit          et;
      logic [31:0] etg;
      do_reset();
      for (int t = 0; t < 200; t++) begin
         rst = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
         if (!rst) model_reset();
         fetch_valid    = 1'($urandom_range(0, 1));
         fetch_pc       = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 8);
         upd_valid      = ($urandom_range(0, 2) != 0);
         upd_pc         = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 1)) << 8);
         upd_taken      = 1'($urandom_range(0, 1));
         upd_target     = $urandom & 32'hFFFF_FFFC;
         upd_ghr        = $urandom_range(0, 1) ? m_ghr : GB'($urandom);
         upd_mispredict = ($urandom_range(0, 3) == 0);
         #1;
         model_predict(fetch_pc, et, etg);
         n_checks++;
         if (pred_taken !== et) begin n_fail++; $display("FAIL rnd_taken[%0d]: got %0b want %0b", t, pred_taken, et); end
         n_checks++;
         if (pred_target !== etg) begin n_fail++; $display("FAIL rnd_target[%0d]: got %h want %h", t, pred_target, etg); end
         n_checks++;
         if (pred_ghr !== m_ghr) begin n_fail++; $display("FAIL rnd_ghr[%0d]: got %h want %h", t, pred_ghr, m_ghr); end
         $display("txn %0d: rst=%0b fv=%0b pc=%h uv=%0b upc=%h t=%0b m=%0b -> taken=%0b target=%h ghr=%h",
                  t, rst, fetch_valid, fetch_pc, upd_valid, upd_pc, upd_taken, upd_mispredict,
                  pred_taken, pred_target, pred_ghr);
         tick();
      end
      rst = 1'b1;
      idle_inputs();
   endtask

   initial begin
      rst      = 1'b0;
      fetch_pc = '0;
      idle_inputs();
      test_reset();
      test_train();
      test_saturation();
      test_recovery();
      test_alias();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
